mux2to1_arbiter: RTL
====================

Name: mux2to1_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one output channel between two valid/ready packet sources.
- Drives the select of the team's 2:1 mux datapath and gates the per-source ready signals.
- Holds each grant for a whole packet, ending at the beat marked last or at a beat-count limit.
- Sits between two producer streams and a single downstream consumer.

Parameters:
DATA_W, 8, width of each source data bus and of the output bus
MAX_BEATS, 16, maximum beats per grant before a forced release (must be >= 1)

Ports:
I_clk  input  1  clock; all logic is rising-edge
I_rst_n  input  1  synchronous active-low reset
I_valid1  input  1  source 1 beat valid
I_last1  input  1  source 1 beat is the last of its packet
I_data1  input  DATA_W  source 1 data
O_ready1  output  1  source 1 beat accepted when high together with I_valid1
I_valid2  input  1  source 2 beat valid
I_last2  input  1  source 2 beat is the last of its packet
I_data2  input  DATA_W  source 2 data
O_ready2  output  1  source 2 beat accepted when high together with I_valid2
I_ready  input  1  downstream ready
O_valid  output  1  output beat valid
O_last  output  1  output last
O_data  output  DATA_W  output data
O_sel  output  1  mux select, registered; 1 = source 1, 0 = source 2
O_gnt  output  2  one-hot grant, registered; bit0 = source 1, bit1 = source 2
O_trunc  output  1  one-cycle pulse when a grant is force-released at MAX_BEATS

Behaviour:
- Reset (I_rst_n low at a clock edge): state=IDLE, O_gnt=00, O_sel=0, O_trunc=0, beat count=0, round-robin pointer=2 (source 1 wins the first tie).
- Reset is synchronous only. Asserting it mid-packet abandons the packet with no flush.
- Combinational outputs while in IDLE: O_valid=0, O_ready1=0, O_ready2=0.
- States and encoding:
  - IDLE: O_gnt=00.
  - G1: O_gnt=01, O_sel=1.
  - G2: O_gnt=10, O_sel=0.
  - O_sel holds its last value in IDLE.
- Grant rule, evaluated in IDLE and at every release:
  - Only one source valid: that source is granted.
  - Both valid: the source not pointed to by the round-robin pointer is granted.
  - Neither valid: go to IDLE.
- Latency:
  - Arbitration from IDLE is registered. A source asserting valid in IDLE sees its grant next cycle, so the first beat transfers no earlier than cycle 2.
  - Back-to-back grants at a release have no bubble: the new grant is effective the cycle after the releasing beat.
- Datapath in Gx is combinational, mux-equivalent:
  - O_valid = I_validx, O_last = I_lastx, O_data = I_datax.
  - O_readyx = I_ready; the non-granted ready = 0.
- Beat = O_valid & I_ready. The beat counter (width clog2(MAX_BEATS+1)) increments on each beat and clears on each new grant.
- Release happens on a beat with O_last=1, or on the beat that makes the count reach MAX_BEATS.
  - At a MAX_BEATS release without last: O_trunc=1 for the next cycle only. The remainder of that packet re-arbitrates as a new grant.
  - last and the MAX_BEATS count on the same beat is a normal release, O_trunc=0.
- On release the pointer is set to the source just released. The grant rule is then applied to the valids sampled in the release cycle.
  - Consequence: with both sources active, grants alternate.
  - With only the releasing source valid, it is re-granted immediately.
- A valid dropped by the granted source mid-packet does not release the grant. The grant persists with O_valid=0 until last or MAX_BEATS.
- Downstream stall (I_ready=0) freezes the counter. Data must stay stable per the source protocol; the arbiter does not register data.

Test Plan:
- Reset with both valids high, then release reset → O_gnt=00 for the first cycle; cycle 1 O_gnt=01, O_sel=1; source 1 data 0xA5 appears on O_data.
- Both sources send 3-beat packets continuously with I_ready=1 → grants alternate 01,10,01,10; no idle cycle between packets; each packet's 3 beats are contiguous; O_last is high on beat 3 of each packet.
- Only source 2 active, 2-beat packets back to back → O_gnt stays 10 throughout; no bubbles after the first grant; O_ready1 stays 0.
- MAX_BEATS=4, source 1 sends a 6-beat packet while source 2 is valid → after beat 4, O_trunc pulses 1 cycle and the grant switches to 10; source 1's remaining 2 beats follow after source 2's packet.
- Toggle I_ready 1,0,0,1 during a granted 4-beat packet → O_ready1 tracks I_ready; the counter counts only 4 accepted beats; release occurs on the last accepted beat.
- Assert I_rst_n=0 for one cycle mid-packet in G2 → next cycle O_gnt=00, O_sel=0, O_valid=0; afterwards source 1 wins a tie.

Source files
------------

// File: rtl/mux2to1_arbiter.sv
// Round-robin packet arbiter for two valid/ready sources sharing one output channel.
// Drives the 2:1 mux select, gates per-source ready and holds each grant for a whole packet.
//
// state | meaning
// IDLE  | no grant; outputs quiet; arbitrate on the current valids
// G1    | source 1 owns the channel (sel = 1)
// G2    | source 2 owns the channel (sel = 0)
module mux2to1_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_valid1,
  input  logic              I_last1,
  input  logic [DATA_W-1:0] I_data1,
  output logic              O_ready1,
  input  logic              I_valid2,
  input  logic              I_last2,
  input  logic [DATA_W-1:0] I_data2,
  output logic              O_ready2,
  input  logic              I_ready,
  output logic              O_valid,
  output logic              O_last,
  output logic [DATA_W-1:0] O_data,
  output logic              O_sel,
  output logic [1:0]        O_gnt,
  output logic              O_trunc
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G1   = 2'b01,
    G2   = 2'b10
  } state_t;

  state_t           state;
  state_t           grant_next;
  logic [CNT_W-1:0] beat_cnt;
  logic             ptr_src2;   // 1: source 2 was served last, so source 1 wins a tie
  logic             ptr_eff;
  logic             beat;
  logic             release_now;

  function automatic state_t arbitrate(input logic v1, input logic v2, input logic p2);
    state_t g;
    if (v1 && v2)
      g = p2 ? G1 : G2;
    else if (v1)
      g = G1;
    else if (v2)
      g = G2;
    else
      g = IDLE;
    return g;
  endfunction

  always_comb begin
    O_valid  = 1'b0;
    O_last   = 1'b0;
    O_data   = '0;
    O_ready1 = 1'b0;
    O_ready2 = 1'b0;
    unique case (state)
      G1: begin
        O_valid  = I_valid1;
        O_last   = I_last1;
        O_data   = I_data1;
        O_ready1 = I_ready;
      end
      G2: begin
        O_valid  = I_valid2;
        O_last   = I_last2;
        O_data   = I_data2;
        O_ready2 = I_ready;
      end
      default: ;
    endcase
  end

  assign beat        = O_valid & I_ready;
  assign release_now = beat & (O_last | (beat_cnt == CNT_LAST));

  // At a release the pointer moves to the releasing source before the tie-break.
  assign ptr_eff    = (state == IDLE) ? ptr_src2 : (state == G2);
  assign grant_next = arbitrate(I_valid1, I_valid2, ptr_eff);

  assign O_gnt = state;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state    <= IDLE;
      O_sel    <= 1'b0;
      O_trunc  <= 1'b0;
      beat_cnt <= '0;
      ptr_src2 <= 1'b1;
    end else begin
      O_trunc <= 1'b0;
      if (state == IDLE || release_now) begin
        state    <= grant_next;
        beat_cnt <= '0;
        if (grant_next == G1)
          O_sel <= 1'b1;
        else if (grant_next == G2)
          O_sel <= 1'b0;
        if (release_now) begin
          ptr_src2 <= (state == G2);
          O_trunc  <= ~O_last;
        end
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule
